bram_req_adapter: RTL and testbench

// - Converts a valid/ready request/response stream into BramPort Master accesses, one per cycle.
// - Sits directly upstream of a BRAM exposed through the BramPort Slave modport.
// - Hides the BRAM's fixed read latency behind a response FIFO.
// - Credit-based flow control gives full throughput and never drops read data under backpressure.
//

---
 rtl/bram_req_adapter_if.sv | 23 ++
 rtl/bram_req_adapter.sv | 124 ++++++++++++
 tb/tb_bram_req_adapter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_req_adapter_if.sv
// BramPort: single-port BRAM access bundle shared by the request adapter and the BRAM.
interface BramPort #(
    parameter int unsigned DATA_BITW = 32,
    parameter int unsigned ADDR_BITW = 32
);
    logic                   Clk_C;
    logic                   Rst_R;
    logic                   En_S;
    logic [DATA_BITW/8-1:0] WrEn_S;
    logic [ADDR_BITW-1:0]   Addr_S;
    logic [DATA_BITW-1:0]   Wr_D;
    logic [DATA_BITW-1:0]   Rd_D;

    modport Master (
        output Clk_C, Rst_R, En_S, WrEn_S, Addr_S, Wr_D,
        input  Rd_D
    );

    modport Slave (
        input  Clk_C, Rst_R, En_S, WrEn_S, Addr_S, Wr_D,
        output Rd_D
    );
endinterface

// File: rtl/bram_req_adapter.sv
// Valid/ready request stream to BramPort adapter with credit-guarded response FIFO.
// Define BRAM_REQ_ADAPTER_WR_ACK_EN to make writes return a zero-data acknowledge response.
module bram_req_adapter #(
    parameter int unsigned DATA_BITW  = 32,
    parameter int unsigned ADDR_BITW  = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RBI,
    input  logic                   Req_Valid_SI,
    output logic                   Req_Ready_SO,
    input  logic                   Req_Wr_SI,
    input  logic [ADDR_BITW-1:0]   Req_Addr_DI,
    input  logic [DATA_BITW-1:0]   Req_Wdata_DI,
    input  logic [DATA_BITW/8-1:0] Req_Be_SI,
    output logic                   Resp_Valid_SO,
    input  logic                   Resp_Ready_SI,
    output logic [DATA_BITW-1:0]   Resp_Rdata_DO,
    BramPort.Master                Bram_PM
);

    localparam int unsigned BE_BITW   = DATA_BITW / 8;
    localparam int unsigned OFFS_BITW = $clog2(BE_BITW);
    localparam int unsigned PTR_BITW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CNT_BITW  = $clog2(RESP_DEPTH + 1);
    localparam logic [ADDR_BITW-1:0] ADDR_MASK =
        ~ADDR_BITW'((64'd1 << OFFS_BITW) - 64'd1);

    logic                 w_acc;
    logic                 w_gen;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_resp_valid;
    logic [DATA_BITW-1:0] w_push_data;
    logic [CNT_BITW-1:0]  w_cnt_nxt;
    logic [CNT_BITW-1:0]  w_fifo_cnt_nxt;

    logic [CNT_BITW-1:0]  r_cnt;
    logic [RD_LAT-1:0]    r_pipe_vld;
    logic [RD_LAT-1:0]    r_pipe_rd;
    logic [PTR_BITW-1:0]  r_wr_ptr;
    logic [PTR_BITW-1:0]  r_rd_ptr;
    logic [CNT_BITW-1:0]  r_fifo_cnt;
    logic [DATA_BITW-1:0] r_mem [RESP_DEPTH];

    function automatic logic [PTR_BITW-1:0] ptr_inc(input logic [PTR_BITW-1:0] p);
        return (p == PTR_BITW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign Req_Ready_SO = Rst_RBI & (r_cnt != CNT_BITW'(RESP_DEPTH));
    assign w_acc        = Req_Valid_SI & Req_Ready_SO;

`ifdef BRAM_REQ_ADAPTER_WR_ACK_EN
    assign w_gen = w_acc;
`else
    assign w_gen = w_acc & ~Req_Wr_SI;
`endif

    assign Bram_PM.Clk_C  = Clk_CI;
    assign Bram_PM.Rst_R  = 1'b0;
    assign Bram_PM.En_S   = w_acc;
    assign Bram_PM.WrEn_S = (w_acc & Req_Wr_SI) ? Req_Be_SI : '0;
    assign Bram_PM.Addr_S = Req_Addr_DI & ADDR_MASK;
    assign Bram_PM.Wr_D   = Req_Wdata_DI;

    // The tail stage lines up with the cycle in which Rd_D holds the data for that request.
    assign w_push      = r_pipe_vld[RD_LAT-1];
    assign w_push_data = r_pipe_rd[RD_LAT-1] ? Bram_PM.Rd_D : '0;

    assign w_resp_valid  = Rst_RBI & (r_fifo_cnt != '0);
    assign w_pop         = w_resp_valid & Resp_Ready_SI;
    assign Resp_Valid_SO = w_resp_valid;
    assign Resp_Rdata_DO = r_mem[r_rd_ptr];

    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_fifo_cnt_nxt = r_fifo_cnt;
        if (w_gen && !w_pop) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (!w_gen && w_pop) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
        if (w_push && !w_pop) begin
            w_fifo_cnt_nxt = r_fifo_cnt + 1'b1;
        end else if (!w_push && w_pop) begin
            w_fifo_cnt_nxt = r_fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_cnt      <= '0;
            r_pipe_vld <= '0;
            r_pipe_rd  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_fifo_cnt    <= w_fifo_cnt_nxt;
            r_pipe_vld[0] <= w_gen;
            r_pipe_rd[0]  <= ~Req_Wr_SI;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_rd[i]  <= r_pipe_rd[i-1];
            end
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

    // Storage is not reset; the pointers alone define occupancy.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RBI && w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

endmodule

// File: tb/tb_bram_req_adapter.sv
// Self-checking bench for bram_req_adapter: behavioural BRAM, queue-based reference model.
module tb_bram_req_adapter;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned RDL   = 1;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata;

    BramPort #(.DATA_BITW(DW), .ADDR_BITW(AW)) bram_if ();

    bram_req_adapter #(
        .DATA_BITW  (DW),
        .ADDR_BITW  (AW),
        .RD_LAT     (RDL),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .Clk_CI        (clk),
        .Rst_RBI       (rst_n),
        .Req_Valid_SI  (req_valid),
        .Req_Ready_SO  (req_ready),
        .Req_Wr_SI     (req_wr),
        .Req_Addr_DI   (req_addr),
        .Req_Wdata_DI  (req_wdata),
        .Req_Be_SI     (req_be),
        .Resp_Valid_SO (resp_valid),
        .Resp_Ready_SI (resp_ready),
        .Resp_Rdata_DO (resp_rdata),
        .Bram_PM       (bram_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural BRAM slave with RDL-cycle registered read.
    logic [DW-1:0] bram_mem [64] = '{default: '0};
    logic [DW-1:0] rd_pipe [RDL] = '{default: '0};
    assign bram_if.Rd_D = rd_pipe[RDL-1];

    always @(posedge clk) begin
        if (bram_if.En_S) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_if.WrEn_S[b]) begin
                    bram_mem[bram_if.Addr_S[7:2]][8*b +: 8] <= bram_if.Wr_D[8*b +: 8];
                end
            end
            rd_pipe[0] <= bram_mem[bram_if.Addr_S[7:2]];
        end
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Reference model: memory image plus queue of expected responses with earliest visible cycle.
    typedef struct {
        logic [DW-1:0] data;
        int            vis;
    } resp_t;

    resp_t         exp_q[$];
    logic [DW-1:0] ref_mem [64] = '{default: '0};
    int            n_resp = 0;
    int            last_acc_cyc = 0;
    logic [DW-1:0] last_resp = '0;
    logic [3:0]    last_wren = '0;
    logic [AW-1:0] last_addr = '0;

    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_eq("rst_req_ready", req_ready, 0);
                check_eq("rst_resp_valid", resp_valid, 0);
                check_eq("rst_bram_en", bram_if.En_S, 0);
                check_eq("rst_bram_wren", bram_if.WrEn_S, 0);
                exp_q.delete();
            end else begin
                check_eq("resp_valid", resp_valid, (exp_q.size() > 0) && (exp_q[0].vis <= cyc));
                check_eq("req_ready", req_ready, exp_q.size() != DEPTH);
                check_eq("credit_bound", exp_q.size() <= DEPTH, 1);
                check_eq("bram_en", bram_if.En_S, req_valid & req_ready);
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("resp_unexpected", 1, 0);
                    end else begin
                        check_eq("resp_data", resp_rdata, exp_q[0].data);
                        void'(exp_q.pop_front());
                    end
                    last_resp = resp_rdata;
                    n_resp++;
                end
                if (req_valid && req_ready) begin
                    last_acc_cyc = cyc;
                    last_wren    = bram_if.WrEn_S;
                    last_addr    = bram_if.Addr_S;
                    check_eq("bram_addr", bram_if.Addr_S, {req_addr[AW-1:2], 2'b00});
                    check_eq("bram_wren", bram_if.WrEn_S, req_wr ? req_be : 4'h0);
                    check_eq("bram_wdata", bram_if.Wr_D, req_wdata);
                    e.vis = cyc + RDL + 1;
                    if (req_wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (req_be[b]) ref_mem[req_addr[7:2]][8*b +: 8] = req_wdata[8*b +: 8];
                        end
`ifdef BRAM_REQ_ADAPTER_WR_ACK_EN
                        e.data = '0;
                        exp_q.push_back(e);
`endif
                    end else begin
                        e.data = ref_mem[req_addr[7:2]];
                        exp_q.push_back(e);
                    end
                end else begin
                    check_eq("bram_wren_idle", bram_if.WrEn_S, 0);
                end
            end
        end
    end

    int stalls = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [3:0] be);
        bit done = 0;
        int waitc = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
        while (!done) begin
            @(negedge clk);
            if (req_ready) done = 1;
            else stalls++;
            tick();
            waitc++;
            if (!done && waitc > 50) begin
                check_eq("send_timeout", 0, 1);
                done = 1;
            end
        end
        req_valid = 1'b0;
    endtask

    // Holds a read request up for max_cyc cycles, stepping the address on each accept.
    task automatic read_burst(input int n, input logic [AW-1:0] base, input int max_cyc,
                              output int acc);
        acc = 0;
        req_wr = 1'b0;
        for (int c = 0; c < max_cyc && acc < n; c++) begin
            req_valid = 1'b1;
            req_addr  = base + AW'(4 * acc);
            @(negedge clk);
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            tick();
            c++;
        end
        check_eq("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int acc;
        int r0;
        bit seen;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", req_ready, 1);
        check_eq("post_rst_valid", resp_valid, 0);
        tick();
        resp_ready = 1'b1;

        // Single read with exact latency
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        wait_idle();
        send(1'b0, 32'h10, '0, 4'h0);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1;
                check_eq("single_latency", cyc - last_acc_cyc, RDL + 1);
                check_eq("single_data", resp_rdata, 32'hDEADBEEF);
            end
        end
        check_eq("single_seen", seen, 1);
        tick();
        wait_idle();

        // Streaming reads at full rate
        for (int i = 0; i < 16; i++) send(1'b1, AW'(4 * i), $urandom, 4'hF);
        wait_idle();
        r0 = n_resp;
        stalls = 0;
        for (int i = 0; i < 16; i++) send(1'b0, AW'(4 * i), '0, 4'h0);
        wait_idle();
        check_eq("stream_stalls", stalls, 0);
        check_eq("stream_count", n_resp - r0, 16);

        // Backpressure fills exactly DEPTH credits
        for (int i = 0; i < 8; i++) send(1'b1, 32'h40 + AW'(4 * i), $urandom, 4'hF);
        wait_idle();
        resp_ready = 1'b0;
        r0 = n_resp;
        read_burst(DEPTH + 3, 32'h40, DEPTH + 8, acc);
        check_eq("bp_accepted", acc, DEPTH);
        @(negedge clk);
        check_eq("bp_ready_low", req_ready, 0);
        tick();
        resp_ready = 1'b1;
        wait_idle();
        check_eq("bp_count", n_resp - r0, DEPTH);

        // Byte enables and address alignment
        send(1'b1, 32'h20, 32'h0, 4'hF);
        send(1'b1, 32'h23, 32'h11223344, 4'h5);
        check_eq("be_wren", last_wren, 4'h5);
        check_eq("be_addr", last_addr, 32'h20);
        send(1'b0, 32'h20, '0, 4'h0);
        wait_idle();
        check_eq("be_readback", last_resp, 32'h00220044);

        // Reset while responses are queued and reads are in flight
        resp_ready = 1'b0;
        read_burst(DEPTH, 32'h00, DEPTH + 4, acc);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_valid", resp_valid, 0);
        check_eq("midrst_cnt", dut.r_cnt, 0);
        tick();
        resp_ready = 1'b1;
        r0 = n_resp;
        send(1'b0, 32'h20, '0, 4'h0);
        wait_idle();
        check_eq("midrst_count", n_resp - r0, 1);
        check_eq("midrst_data", last_resp, 32'h00220044);

        // Write, read, write ordering
        r0 = n_resp;
        send(1'b1, 32'h84, 32'hCAFEF00D, 4'hF);
        send(1'b0, 32'h84, '0, 4'h0);
        send(1'b1, 32'h88, 32'h12345678, 4'hF);
        wait_idle();
`ifdef BRAM_REQ_ADAPTER_WR_ACK_EN
        check_eq("wrw_count", n_resp - r0, 3);
        check_eq("wrw_last", last_resp, 0);
`else
        check_eq("wrw_count", n_resp - r0, 1);
        check_eq("wrw_last", last_resp, 32'hCAFEF00D);
`endif

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            req_valid  = ($urandom % 4) != 0;
            req_wr     = $urandom % 2;
            req_addr   = AW'($urandom_range(0, 255));
            req_wdata  = $urandom;
            req_be     = 4'($urandom);
            resp_ready = ($urandom % 4) != 0;
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
